// File: rtl/led_anim_pkg.sv
// Shared types, default constants and the triangular duty map
// used by the LED breathing sequencer and its bench model.
package led_anim_pkg;

   typedef enum logic {
      ST_IDLE,
      ST_RUN
   } state_t;

   localparam int MAX_DUTY_DEF   = 10;
   localparam int PWM_PERIOD_DEF = 10;
   localparam int PHASE_OFS_DEF  = 2;

   // Triangle 0 -> max_duty -> 0 over positions 0..2*max_duty,
   // shifted right by ch*phase_ofs; zero outside the window.
   function automatic int tri_duty(
      input int pos,
      input int ch,
      input int max_duty  = MAX_DUTY_DEF,
      input int phase_ofs = PHASE_OFS_DEF
   );
      int p;
      int r;
      p = pos - ch * phase_ofs;
      r = 0;
      if (p >= 0 && p <= max_duty)
         r = p;
      else if (p > max_duty && p <= 2 * max_duty)
         r = 2 * max_duty - p;
      return r;
   endfunction

endpackage

// File: rtl/led_breath_sequencer_pwm.sv
// Single PWM channel: free-running frame counter with a shadowed duty.
// Ports: clk, rst, duty_i (requested level), pwm_o (registered drive).
module pwm_channel
   import led_anim_pkg::*;
#(
   parameter int DUTY_W     = 4,
   parameter int PWM_PERIOD = PWM_PERIOD_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DUTY_W-1:0] duty_i,
   output logic              pwm_o
);

   localparam int CNT_W = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PWM_PERIOD - 1);

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DUTY_W-1:0] shd_q, shd_d;
   logic              pwm_q;
   logic              wrap;

   // Duty only enters the shadow as the frame restarts, so a
   // mid-frame change never produces a runt pulse.
   always_comb begin
      wrap  = (cnt_q == CNT_LAST);
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
      shd_d = wrap ? duty_i : shd_q;
   end

   // Output is computed from the next-state values so that the
   // registered level lines up with the registered count.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         shd_q <= '0;
         pwm_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         shd_q <= shd_d;
         pwm_q <= (32'(cnt_d) < 32'(shd_d));
      end
   end

   assign pwm_o = pwm_q;

endmodule

// File: rtl/led_breath_sequencer.sv
// Multi-channel LED breathing sequencer: sweep FSM, step timer,
// shared position counter, phase-staggered triangular duty, PWM drive.
// Ports: clk, rst, start, stop, mode_repeat, t_rise, t_fall in;
//        busy, done, duty (packed per channel), pwm_out out.
module led_breath_sequencer
   import led_anim_pkg::*;
#(
   parameter int NUM_CH     = 4,
   parameter int DUTY_W     = 4,
   parameter int MAX_DUTY   = MAX_DUTY_DEF,
   parameter int PHASE_OFS  = PHASE_OFS_DEF,
   parameter int STEP_W     = 6,
   parameter int PWM_PERIOD = PWM_PERIOD_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     stop,
   input  logic                     mode_repeat,
   input  logic [STEP_W-1:0]        t_rise,
   input  logic [STEP_W-1:0]        t_fall,
   output logic                     busy,
   output logic                     done,
   output logic [NUM_CH*DUTY_W-1:0] duty,
   output logic [NUM_CH-1:0]        pwm_out
);

   localparam int LAST_POS = 2 * MAX_DUTY + (NUM_CH - 1) * PHASE_OFS;
   localparam int POS_W    = (LAST_POS > 0) ? $clog2(LAST_POS + 1) : 1;
   localparam logic [POS_W-1:0] LAST_P = POS_W'(LAST_POS);
   localparam logic [POS_W-1:0] MAX_P  = POS_W'(MAX_DUTY);

   if (MAX_DUTY >= (1 << DUTY_W) || NUM_CH < 1) begin : g_bad_cfg
      $error("led_breath_sequencer: bad MAX_DUTY/DUTY_W/NUM_CH");
   end

   state_t                  state_q;
   logic [POS_W-1:0]        pos_q;
   logic [STEP_W-1:0]       tmr_q;
   logic [STEP_W-1:0]       rise_q, fall_q;
   logic                    rep_q;
   logic                    busy_q, done_q;
   logic [NUM_CH*DUTY_W-1:0] duty_q;

   logic [STEP_W-1:0] hold_sel;
   logic [STEP_W-1:0] hold_m1;
   logic              expire;

   // A zero hold time behaves like one cycle per step.
   always_comb begin
      hold_sel = (pos_q < MAX_P) ? rise_q : fall_q;
      hold_m1  = (hold_sel == '0) ? '0 : hold_sel - 1'b1;
      expire   = (tmr_q == hold_m1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         pos_q   <= '0;
         tmr_q   <= '0;
         rise_q  <= '0;
         fall_q  <= '0;
         rep_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (start && !stop) begin
                  state_q <= ST_RUN;
                  busy_q  <= 1'b1;
                  rise_q  <= t_rise;
                  fall_q  <= t_fall;
                  rep_q   <= mode_repeat;
                  pos_q   <= '0;
                  tmr_q   <= '0;
               end
            end
            ST_RUN: begin
               if (stop) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
                  pos_q   <= '0;
                  tmr_q   <= '0;
               end else if (expire) begin
                  tmr_q <= '0;
                  if (pos_q == LAST_P) begin
                     done_q <= 1'b1;
                     pos_q  <= '0;
                     if (!rep_q) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                     end
                  end else begin
                     pos_q <= pos_q + 1'b1;
                  end
               end else begin
                  tmr_q <= tmr_q + 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Duty follows the position one cycle later; pos is 0 in IDLE,
   // which maps every channel to 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         duty_q <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++)
            duty_q[i*DUTY_W +: DUTY_W] <=
               DUTY_W'(tri_duty(int'(pos_q), i, MAX_DUTY, PHASE_OFS));
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_pwm
      pwm_channel #(
         .DUTY_W     (DUTY_W),
         .PWM_PERIOD (PWM_PERIOD)
      ) u_pwm (
         .clk    (clk),
         .rst    (rst),
         .duty_i (duty_q[g*DUTY_W +: DUTY_W]),
         .pwm_o  (pwm_out[g])
      );
   end

   assign busy = busy_q;
   assign done = done_q;
   assign duty = duty_q;

endmodule

// File: tb/tb_led_breath_sequencer.sv
// Directed bench for the LED breathing sequencer and its PWM channel.
// Vector table for the basic sweep plus hand sequences for corner cases.
module tb_led_breath_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        mode_repeat = 1'b0;
   logic [5:0]  t_rise = 6'd1;
   logic [5:0]  t_fall = 6'd1;
   logic        busy, done;
   logic [15:0] duty;
   logic [3:0]  pwm_out;

   logic [3:0]  pd = 4'd0;
   logic        pw;

   int total  = 0;
   int passed = 0;

   typedef struct {
      int          cyc;
      logic        busy;
      logic        done;
      logic [15:0] duty;
   } vec_t;

   vec_t tv[8];

   always #5 clk = ~clk;

   led_breath_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .stop        (stop),
      .mode_repeat (mode_repeat),
      .t_rise      (t_rise),
      .t_fall      (t_fall),
      .busy        (busy),
      .done        (done),
      .duty        (duty),
      .pwm_out     (pwm_out)
   );

   pwm_channel #(.DUTY_W(4), .PWM_PERIOD(10)) u_pwm (
      .clk    (clk),
      .rst    (rst),
      .duty_i (pd),
      .pwm_o  (pw)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act === exp)
         passed++;
      else
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic launch(input logic [5:0] r, input logic [5:0] f,
                         input logic rep);
      t_rise      = r;
      t_fall      = f;
      mode_repeat = rep;
      start       = 1'b1;
      tick();
      start       = 1'b0;
   endtask

   initial begin
      int j;
      int n;
      int hi;
      int nd;
      int first_done;
      int blow;
      logic prev;
      logic found;

      // {cycle after start edge, busy, done, packed duty ch3..ch0}
      tv[0] = '{1,  1'b1, 1'b0, 16'h0000};
      tv[1] = '{8,  1'b1, 1'b0, 16'h1357};
      tv[2] = '{11, 1'b1, 1'b0, 16'h468A};
      tv[3] = '{13, 1'b1, 1'b0, 16'h68A8};
      tv[4] = '{21, 1'b1, 1'b0, 16'h6420};
      tv[5] = '{26, 1'b1, 1'b0, 16'h1000};
      tv[6] = '{27, 1'b0, 1'b1, 16'h0000};
      tv[7] = '{28, 1'b0, 1'b0, 16'h0000};

      // Reset state
      tick();
      tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_duty", 32'(duty), 32'd0);
      chk("rst_pwm", 32'(pwm_out), 32'd0);
      pd  = 4'd4;
      rst = 1'b0;

      // PWM channel: 4/10, mid-frame change, saturation, zero
      found = 1'b0;
      prev  = pw;
      for (int i = 0; i < 40 && !found; i++) begin
         tick();
         if (pw && !prev) found = 1'b1;
         prev = pw;
      end
      chk("pwm_rise_seen", 32'(found), 32'd1);
      tick();
      tick();
      pd = 4'd7;
      hi = 0;
      for (int i = 0; i < 7; i++) begin
         tick();
         hi += int'(pw);
      end
      chk("pwm_old_frame", 32'(hi), 32'd1);
      hi = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         hi += int'(pw);
      end
      chk("pwm_new_frame", 32'(hi), 32'd7);
      pd = 4'd15;
      hi = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         hi += int'(pw);
      end
      chk("pwm_sat", 32'(hi), 32'd20);
      pd = 4'd0;
      for (int i = 0; i < 10; i++) tick();
      hi = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         hi += int'(pw);
      end
      chk("pwm_zero", 32'(hi), 32'd0);

      // Basic sweep, t_rise=t_fall=1, one-shot
      launch(6'd1, 6'd1, 1'b0);
      chk("t1_busy_e0", 32'(busy), 32'd1);
      j  = 0;
      nd = 0;
      for (int k = 1; k <= 28; k++) begin
         tick();
         if (done) nd++;
         if (j < 8 && tv[j].cyc == k) begin
            chk($sformatf("t1_busy_%0d", k), 32'(busy), 32'(tv[j].busy));
            chk($sformatf("t1_done_%0d", k), 32'(done), 32'(tv[j].done));
            chk($sformatf("t1_duty_%0d", k), 32'(duty), 32'(tv[j].duty));
            j++;
         end
      end
      chk("t1_done_count", 32'(nd), 32'd1);

      // Unequal hold times: 10*3 + 17*5 = 115
      launch(6'd3, 6'd5, 1'b0);
      n = 0;
      while (!done && n < 200) begin
         tick();
         n++;
      end
      chk("t3_done_cycle", 32'(n), 32'd115);
      chk("t3_busy_end", 32'(busy), 32'd0);

      // Zero hold treated as one cycle per step
      launch(6'd0, 6'd0, 1'b0);
      n = 0;
      while (!done && n < 100) begin
         tick();
         n++;
      end
      chk("t0_done_cycle", 32'(n), 32'd27);

      // Repeat mode, then stop mid-sweep at pos=13
      launch(6'd1, 6'd1, 1'b1);
      nd         = 0;
      first_done = 0;
      blow       = 0;
      for (int k = 1; k <= 67; k++) begin
         tick();
         if (done) begin
            nd++;
            if (first_done == 0) first_done = k;
         end
         if (!busy) blow++;
      end
      chk("rep_first_done", 32'(first_done), 32'd27);
      chk("rep_done_count", 32'(nd), 32'd2);
      chk("rep_busy_low", 32'(blow), 32'd0);
      start = 1'b1;
      stop  = 1'b1;
      tick();
      start = 1'b0;
      stop  = 1'b0;
      chk("stop_busy", 32'(busy), 32'd0);
      chk("stop_done", 32'(done), 32'd0);
      chk("stop_duty_lag", 32'(duty), 32'h7997);
      nd = 0;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (done) nd++;
      end
      chk("stop_duty_zero", 32'(duty), 32'd0);
      chk("stop_no_done", 32'(nd), 32'd0);

      // start with stop in IDLE stays idle
      start = 1'b1;
      stop  = 1'b1;
      tick();
      start = 1'b0;
      stop  = 1'b0;
      chk("ss_idle", 32'(busy), 32'd0);

      // Reset at pos=20 with start held, then fresh sweep
      launch(6'd1, 6'd1, 1'b0);
      for (int k = 1; k <= 20; k++) tick();
      chk("r6_pre_busy", 32'(busy), 32'd1);
      rst   = 1'b1;
      start = 1'b1;
      tick();
      chk("r6_busy", 32'(busy), 32'd0);
      chk("r6_done", 32'(done), 32'd0);
      chk("r6_duty", 32'(duty), 32'd0);
      chk("r6_pwm", 32'(pwm_out), 32'd0);
      rst = 1'b0;
      tick();
      start = 1'b0;
      chk("r6_restart", 32'(busy), 32'd1);
      for (int k = 1; k <= 8; k++) tick();
      chk("r6_duty_p7", 32'(duty), 32'h1357);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
